// File: rtl/id_range_scanner_if.sv
// Range submission bus for id_range_scanner: BCD bounds, puzzle mode and job-last flag.
// Transfers on a rising edge while range_valid and range_ready are both high.
interface id_range_scanner_if #(
   parameter int unsigned DIGITS = 12
);
   logic                range_valid;
   logic                range_ready;
   logic [4*DIGITS-1:0] range_start;
   logic [4*DIGITS-1:0] range_end;
   logic                range_mode;
   logic                range_last;

   modport master (
      output range_valid, range_start, range_end, range_mode, range_last,
      input  range_ready
   );

   modport slave (
      input  range_valid, range_start, range_end, range_mode, range_last,
      output range_ready
   );
endinterface

// File: rtl/id_range_scanner.sv
// Scans queued BCD ID ranges one ID per cycle and accumulates the sum and count of IDs
// whose digits form a repeated pattern (two halves in mode 0, any period in mode 1).
module id_range_scanner #(
   parameter int unsigned DIGITS     = 12,
   parameter int unsigned W          = 48,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   id_range_scanner_if.slave   rng,
   input  logic                clear,
   output logic [W-1:0]        id_sum,
   output logic [31:0]         id_count,
   output logic                busy,
   output logic                done
);
   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StConvert, StScan} state_e;

   // Range FIFO; pointers carry one extra wrap bit to tell full from empty.
   logic [BW-1:0]         fifo_start_q [FIFO_DEPTH];
   logic [BW-1:0]         fifo_end_q   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_mode_q;
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic                  fifo_empty, fifo_full, push, pop;

   state_e                state_q, state_d;
   logic [BW-1:0]         cur_q, end_q, bin_q, cur_inc, bin_conv;
   logic [CW-1:0]         dig_q;
   logic [3:0]            cur_digit;
   logic                  mode_q, last_q, in_range, carry;
   logic                  conv_en, issue_id, issue_marker;

   logic                  s1_valid_q, s1_is_id_q, s1_mode_q, s1_last_q;
   logic [BW-1:0]         s1_bcd_q, s1_bin_q;
   logic                  s1_invalid, period_ok, cand;
   int                    n;

   logic [W-1:0]          sum_q;
   logic [31:0]           count_q;
   logic                  done_q;

   assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
   assign fifo_full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rng.range_ready = !fifo_full;
   assign push            = rng.range_valid && !fifo_full;

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_start_q[wr_ptr_q[AW-1:0]] <= rng.range_start;
         fifo_end_q[wr_ptr_q[AW-1:0]]   <= rng.range_end;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_mode_q <= '0;
         fifo_last_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q                      <= wr_ptr_q + (AW + 1)'(1);
            fifo_mode_q[wr_ptr_q[AW-1:0]] <= rng.range_mode;
            fifo_last_q[wr_ptr_q[AW-1:0]] <= rng.range_last;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
         end
      end
   end

   // Equal-width BCD compares like its decimal magnitude.
   assign in_range = (cur_q <= end_q);

   always_comb begin
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q == CW'(i)) cur_digit = cur_q[4*i +: 4];
      end
      bin_conv = (bin_q << 3) + (bin_q << 1) + BW'(cur_digit);
   end

   always_comb begin
      carry   = 1'b1;
      cur_inc = cur_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (cur_q[4*i +: 4] == 4'd9) begin
               cur_inc[4*i +: 4] = 4'd0;
            end else begin
               cur_inc[4*i +: 4] = cur_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (!fifo_empty) state_d = StConvert;
         StConvert: if (dig_q == '0) state_d = StScan;
         StScan:    if (!in_range)   state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      pop          = 1'b0;
      conv_en      = 1'b0;
      issue_id     = 1'b0;
      issue_marker = 1'b0;
      unique case (state_q)
         StIdle:    pop = !fifo_empty;
         StConvert: conv_en = 1'b1;
         StScan: begin
            issue_id     = in_range;
            issue_marker = !in_range;
         end
         default: ;
      endcase
   end

   // Working registers: BCD cursor, its binary shadow and the MSD-first convert index.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_q  <= '0;
         end_q  <= '0;
         bin_q  <= '0;
         dig_q  <= '0;
         mode_q <= 1'b0;
         last_q <= 1'b0;
      end else if (pop) begin
         cur_q  <= fifo_start_q[rd_ptr_q[AW-1:0]];
         end_q  <= fifo_end_q[rd_ptr_q[AW-1:0]];
         mode_q <= fifo_mode_q[rd_ptr_q[AW-1:0]];
         last_q <= fifo_last_q[rd_ptr_q[AW-1:0]];
         bin_q  <= '0;
         dig_q  <= CW'(DIGITS - 1);
      end else if (conv_en) begin
         bin_q <= bin_conv;
         dig_q <= dig_q - CW'(1);
      end else if (issue_id) begin
         cur_q <= cur_inc;
         bin_q <= bin_q + BW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_is_id_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_bcd_q   <= '0;
         s1_bin_q   <= '0;
      end else begin
         s1_valid_q <= issue_id || issue_marker;
         s1_is_id_q <= issue_id;
         s1_mode_q  <= mode_q;
         s1_last_q  <= last_q;
         s1_bcd_q   <= cur_q;
         s1_bin_q   <= bin_q;
      end
   end

   // A period p qualifies when every digit below n-p matches the digit p places above it.
   always_comb begin
      n          = 0;
      period_ok  = 1'b0;
      cand       = 1'b0;
      s1_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s1_bcd_q[4*i +: 4] != 4'd0) n = i + 1;
      end
      for (int p = 1; p <= DIGITS / 2; p++) begin
         period_ok = 1'b1;
         for (int i = 0; i + p < DIGITS; i++) begin
            if ((i + p < n) && (s1_bcd_q[4*i +: 4] != s1_bcd_q[4*(i+p) +: 4])) begin
               period_ok = 1'b0;
            end
         end
         if (s1_mode_q) cand = (2 * p <= n) && (n % p == 0);
         else           cand = (2 * p == n);
         if (cand && period_ok) s1_invalid = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum_q   <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else if (clear) begin
         sum_q   <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else if (s1_valid_q) begin
         if (s1_is_id_q && s1_invalid) begin
            sum_q   <= sum_q + W'(s1_bin_q);
            count_q <= count_q + 32'd1;
         end
         if (!s1_is_id_q && s1_last_q) done_q <= 1'b1;
      end
   end

   assign id_sum   = sum_q;
   assign id_count = count_q;
   assign done     = done_q;
   assign busy     = !fifo_empty || (state_q != StIdle) || s1_valid_q;

endmodule
